// File: rtl/sincos_pkg.sv
// Shared constants, encodings and the elaboration-time coefficient builder
// for the quarter-wave piecewise-linear sine/cosine generator.
package sincos_pkg;

   localparam int PHASE_W    = 16;
   localparam int OUT_W      = 16;
   localparam int FRAC_W     = 15;
   localparam int COEF0_W    = 18;
   localparam int COEF1_W    = 12;
   localparam int GUARD      = 2;
   localparam int X_W        = PHASE_W - 2;
   localparam int SLOPE_FRAC = 7;
   localparam int ACC_W      = 32;
   localparam int TAYLOR_Q   = 30;

   localparam longint HALF_PI_Q = 64'sd1686629713;
   localparam longint ONE_Q     = 64'sd1073741824;

   typedef enum logic [1:0] {
      QUAD_0 = 2'd0,
      QUAD_1 = 2'd1,
      QUAD_2 = 2'd2,
      QUAD_3 = 2'd3
   } quadrant_e;

   typedef enum logic {
      FN_COS = 1'b0,
      FN_SIN = 1'b1
   } pwl_fn_e;

   // f(k/2^addr_w) in Q2.30, integer Taylor series so any elaborator can fold it.
   function automatic longint pwl_eval(pwl_fn_e fn, int addr_w, int k);
      longint a, a2, term, sum, div;
      a    = (HALF_PI_Q * longint'(k)) >>> addr_w;
      a2   = (a * a) >>> TAYLOR_Q;
      term = (fn == FN_COS) ? ONE_Q : a;
      sum  = 64'sd0;
      for (int n = 0; n < 12; n++) begin
         sum = sum + term;
         if (fn == FN_COS) div = longint'((2 * n + 1) * (2 * n + 2));
         else              div = longint'((2 * n + 2) * (2 * n + 3));
         term = -(((term * a2) >>> TAYLOR_Q) / div);
      end
      return sum;
   endfunction

   function automatic logic [COEF0_W-1:0] pwl_c0(pwl_fn_e fn, int addr_w, int k);
      int sh;
      sh = TAYLOR_Q - (FRAC_W + GUARD);
      return COEF0_W'((pwl_eval(fn, addr_w, k) + (64'sd1 <<< (sh - 1))) >>> sh);
   endfunction

   // Slope carries SLOPE_FRAC extra fraction bits so its rounding error stays sub-LSB.
   function automatic logic [COEF1_W-1:0] pwl_c1(pwl_fn_e fn, int addr_w, int k);
      int     sh;
      longint d;
      sh = TAYLOR_Q - (FRAC_W + GUARD + SLOPE_FRAC) + (X_W - addr_w);
      d  = pwl_eval(fn, addr_w, k + 1) - pwl_eval(fn, addr_w, k);
      return COEF1_W'((d + (64'sd1 <<< (sh - 1))) >>> sh);
   endfunction

   function automatic logic [OUT_W-1:0] q15_pos(logic [FRAC_W-1:0] m);
      return {1'b0, m};
   endfunction

   function automatic logic [OUT_W-1:0] q15_neg(logic [FRAC_W-1:0] m);
      return 16'd0 - {1'b0, m};
   endfunction

endpackage

// File: rtl/sincos_quarter_pwl.sv
// Combinational quarter-wave piecewise-linear evaluator: ROM lookup,
// multiply-add at full width, then round and clamp to a non-negative Q1.15.
module quarter_pwl
   import sincos_pkg::*;
#(
   parameter int      ADDR_W = 7,
   parameter pwl_fn_e FN     = FN_COS
) (
   input  logic [X_W-1:0]    x,
   input  logic [FRAC_W-1:0] y_unused_guard,
   output logic [FRAC_W-1:0] y
);

   localparam int N_SEG = 1 << ADDR_W;
   localparam int R_W   = X_W - ADDR_W;
   localparam int SH    = SLOPE_FRAC + GUARD;

   logic [COEF0_W-1:0] c0_rom [N_SEG];
   logic [COEF1_W-1:0] c1_rom [N_SEG];

   for (genvar g = 0; g < N_SEG; g++) begin : g_rom
      assign c0_rom[g] = pwl_c0(FN, ADDR_W, g);
      assign c1_rom[g] = pwl_c1(FN, ADDR_W, g);
   end

   logic [ADDR_W-1:0]  k_s;
   logic [R_W-1:0]     r_s;
   logic [COEF0_W-1:0] c0_s;
   logic [COEF1_W-1:0] c1_s;
   logic [ACC_W-1:0]   base_s;
   logic [ACC_W-1:0]   prod_s;
   logic [ACC_W-1:0]   sum_s;
   logic [ACC_W-1:0]   shifted_s;

   assign k_s = x[X_W-1 -: ADDR_W];
   assign r_s = x[R_W-1:0];

   // Segment evaluation; a negative sum (cosine tail) clamps to zero.
   always_comb begin
      c0_s      = c0_rom[k_s];
      c1_s      = c1_rom[k_s];
      base_s    = {{(ACC_W - COEF0_W){1'b0}}, c0_s} << SLOPE_FRAC;
      prod_s    = {{(ACC_W - COEF1_W){c1_s[COEF1_W-1]}}, c1_s}
                * {{(ACC_W - R_W){1'b0}}, r_s};
      sum_s     = base_s + prod_s + (32'd1 << (SH - 1));
      shifted_s = sum_s >> SH;
      if (sum_s[ACC_W-1]) begin
         y = 15'd0;
      end else if (shifted_s > 32'd32767) begin
         y = 15'h7FFF;
      end else begin
         y = shifted_s[FRAC_W-1:0];
      end
   end

endmodule

// File: rtl/sincos.sv
// Box-Muller sin/cos stage: quadrant split, two quarter-wave PWL tables,
// quadrant mux with negation, and a single output register.
module sincos
   import sincos_pkg::*;
#(
   parameter int B_x_g_aa = 7,
   parameter int B_x_g_ba = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PHASE_W-1:0]  sincos_in,
   output logic [OUT_W-1:0]    sincos_out1,
   output logic [OUT_W-1:0]    sincos_out2
);

   quadrant_e          quad_s;
   logic [X_W-1:0]     x_s;
   logic [FRAC_W-1:0]  cos_mag_s;
   logic [FRAC_W-1:0]  sin_mag_s;
   logic [OUT_W-1:0]   sin_s;
   logic [OUT_W-1:0]   cos_s;
   logic [OUT_W-1:0]   out1_r;
   logic [OUT_W-1:0]   out2_r;

   assign quad_s = quadrant_e'(sincos_in[PHASE_W-1 -: 2]);
   assign x_s    = sincos_in[X_W-1:0];

   quarter_pwl #(.ADDR_W(B_x_g_aa), .FN(FN_COS)) u_cos (
      .x              (x_s),
      .y_unused_guard (15'd0),
      .y              (cos_mag_s)
   );

   quarter_pwl #(.ADDR_W(B_x_g_ba), .FN(FN_SIN)) u_sin (
      .x              (x_s),
      .y_unused_guard (15'd0),
      .y              (sin_mag_s)
   );

   // Quadrant symmetry: A = cos table, B = sin table.
   always_comb begin
      sin_s = 16'd0;
      cos_s = 16'd0;
      case (quad_s)
         QUAD_0: begin sin_s = q15_pos(sin_mag_s); cos_s = q15_pos(cos_mag_s); end
         QUAD_1: begin sin_s = q15_pos(cos_mag_s); cos_s = q15_neg(sin_mag_s); end
         QUAD_2: begin sin_s = q15_neg(sin_mag_s); cos_s = q15_neg(cos_mag_s); end
         QUAD_3: begin sin_s = q15_neg(cos_mag_s); cos_s = q15_pos(sin_mag_s); end
         default: begin sin_s = 16'd0; cos_s = 16'd0; end
      endcase
   end

   // Output register; reset clears both results asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out1_r <= 16'd0;
         out2_r <= 16'd0;
      end else begin
         out1_r <= sin_s;
         out2_r <= cos_s;
      end
   end

   assign sincos_out1 = out1_r;
   assign sincos_out2 = out2_r;

endmodule

// File: tb/tb_sincos.sv
// Self-checking bench for sincos: directed vector table, exhaustive phase sweep,
// random stream and asynchronous reset sequences against a real-valued model.
module tb_sincos;

   logic        clk;
   logic        rst;
   logic [15:0] sincos_in;
   logic [15:0] sincos_out1;
   logic [15:0] sincos_out2;

   int n_vec = 0;
   int n_bad = 0;

   sincos dut (
      .clk         (clk),
      .rst         (rst),
      .sincos_in   (sincos_in),
      .sincos_out1 (sincos_out1),
      .sincos_out2 (sincos_out2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] u;
      int          e1;
      int          e2;
      int          tol;
   } vec_t;

   function automatic int rnd(real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      else          return -$rtoi(-v + 0.5);
   endfunction

   // Reference: round(32767 * f(2*pi*u/65536)).
   function automatic int ref_val(logic [15:0] u, bit is_cos);
      real ang;
      ang = 2.0 * 3.141592653589793 * real'(u) / 65536.0;
      if (is_cos) return rnd(32767.0 * $cos(ang));
      else        return rnd(32767.0 * $sin(ang));
   endfunction

   task automatic chk(input string name, input int act, input int exp, input int tol);
      n_vec++;
      if ((act - exp > tol) || (exp - act > tol)) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   task automatic chk_phase(input logic [15:0] u, input bit full);
      int  s, c;
      real p;
      s = int'($signed(sincos_out1));
      c = int'($signed(sincos_out2));
      chk($sformatf("sin u=%h", u), s, ref_val(u, 1'b0), 2);
      chk($sformatf("cos u=%h", u), c, ref_val(u, 1'b1), 2);
      if (full) begin
         n_vec++;
         if (sincos_out1 == 16'h8000 || sincos_out2 == 16'h8000) begin
            n_bad++;
            $display("FAIL no8000 u=%h: got %h/%h, expected neither 8000",
                     u, sincos_out1, sincos_out2);
         end
         p = (real'(s) * real'(s) + real'(c) * real'(c)) / 1073741824.0;
         n_vec++;
         if (p > 1.0 + 1.0 / 8192.0 || p < 1.0 - 1.0 / 8192.0) begin
            n_bad++;
            $display("FAIL sumsq u=%h: got %f, expected 1.0 +/- 2^-13", u, p);
         end
      end
   endtask

   vec_t tbl [9];
   logic [15:0] rq [$];

   initial begin
      tbl[0] = '{16'h0000,      0,  32767, 0};
      tbl[1] = '{16'h4000,  32767,      0, 0};
      tbl[2] = '{16'h8000,      0, -32767, 0};
      tbl[3] = '{16'hC000, -32767,      0, 0};
      tbl[4] = '{16'h2000,  23170,  23170, 2};
      tbl[5] = '{16'h6000,  23170, -23170, 2};
      tbl[6] = '{16'h3FFF,  32767,      3, 2};
      tbl[7] = '{16'h4001,  32767,     -3, 2};
      tbl[8] = '{16'hFFFF,     -3,  32767, 2};

      // Reset state, then the release and first result.
      rst       = 1'b1;
      sincos_in = 16'h0000;
      #12;
      chk("rst out1", int'(sincos_out1), 0, 0);
      chk("rst out2", int'(sincos_out2), 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("release out1", int'(sincos_out1), 0, 0);
      chk("release out2", int'(sincos_out2), 0, 0);
      @(posedge clk);
      #1;
      chk("first out1", int'($signed(sincos_out1)), 0, 0);
      chk("first out2", int'($signed(sincos_out2)), 32767, 0);

      // Directed table, streamed one vector per cycle.
      for (int i = 0; i <= 9; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk($sformatf("tbl%0d out1 u=%h", i - 1, tbl[i-1].u),
                int'($signed(sincos_out1)), tbl[i-1].e1, tbl[i-1].tol);
            chk($sformatf("tbl%0d out2 u=%h", i - 1, tbl[i-1].u),
                int'($signed(sincos_out2)), tbl[i-1].e2, tbl[i-1].tol);
         end
         if (i < 9) sincos_in = tbl[i].u;
      end

      // Exhaustive sweep of every phase.
      for (int i = 0; i <= 65536; i++) begin
         @(negedge clk);
         if (i > 0) chk_phase(16'(i - 1), 1'b1);
         if (i < 65536) sincos_in = 16'(i);
      end

      // Mid-stream asynchronous reset.
      @(negedge clk);
      sincos_in = 16'h1234;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst out1", int'(sincos_out1), 0, 0);
      chk("async rst out2", int'(sincos_out2), 0, 0);
      @(posedge clk);
      #1;
      chk("held rst out1", int'(sincos_out1), 0, 0);
      chk("held rst out2", int'(sincos_out2), 0, 0);
      @(negedge clk);
      rst       = 1'b0;
      sincos_in = 16'h2000;
      #1;
      chk("post rst idle out1", int'(sincos_out1), 0, 0);
      @(posedge clk);
      #1;
      chk("post rst out1", int'($signed(sincos_out1)), 23170, 2);
      chk("post rst out2", int'($signed(sincos_out2)), 23170, 2);

      // Random stream against the model, expected inputs queued.
      for (int i = 0; i <= 400; i++) begin
         @(negedge clk);
         if (i > 0) chk_phase(rq.pop_front(), 1'b0);
         if (i < 400) begin
            sincos_in = 16'($urandom_range(0, 65535));
            rq.push_back(sincos_in);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
